traffic_phase_scheduler: RTL and testbench
==========================================

// Module: traffic_phase_scheduler
// PURPOSE
// Demand-actuated phase scheduler for the four-way intersection. Replaces the fixed
// N->S->E->W rotation with round-robin service of only those approaches that have
// vehicle demand. Provides green extension, an all-red clearance interval and
// emergency pre-emption. Drives the same 2-bit per-approach light buses as the
// fixed controller: 10=green, 01=yellow, 00=red.
// PARAMETERS
// GREEN_MIN  4   minimum green cycles before a demanded phase change
// GREEN_MAX  12  green cycles after which extension by own sensor ends
// YELLOW_T   2   yellow cycles (>=1)
// ALLRED_T   1   minimum all-red clearance cycles (>=1)
// CNT_W      5   phase counter width; must hold max(GREEN_MAX,YELLOW_T,ALLRED_T)-1
// PORTS
// clk        in   1  clock
// rst        in   1  asynchronous reset, active-low
// sensor     in   4  vehicle presence, level; bit0=N,1=S,2=E,3=W
// emerg      in   4  emergency pre-empt request, level; same bit order
// n_lights   out  2  north light code
// s_lights   out  2  south light code
// e_lights   out  2  east light code
// w_lights   out  2  west light code
// phase      out  2  current phase_t
// cur_dir    out  2  direction owning GREEN/YELLOW (last served while ALL_RED)
// pend       out  4  latched request vector req_q
// BEHAVIOUR
// - Reset (rst=0, async): phase=ALL_RED, count=0, cur_dir=W(3), req_q=0, all lights 00.
// - Each entry into a phase clears count to 0. Otherwise count increments, saturating
//   at the phase terminal value (ALLRED_T-1, GREEN_MAX-1 or YELLOW_T-1).
// - Request latch: req_q[i] <= req_q[i] | sensor[i] | emerg[i] each clk; visible 1 cycle
//   later. req_q[cur_dir] is not set while phase=GREEN. A bit is cleared on the edge that
//   grants GREEN to it; the clear wins over a simultaneous set.
// - other = |(req_q & ~onehot(cur_dir)).
// - Emergency target etgt = lowest set bit of emerg; eact = |emerg.
// - ALL_RED: when count==ALLRED_T-1 and (eact or req_q!=0), go to GREEN.
//   cur_dir = etgt if eact, else first set req_q bit scanning cur_dir+1, +2, +3, +0
//   (mod 4). Otherwise hold ALL_RED, all lights 00.
// - GREEN: light[cur_dir]=10, all others 00. Go to YELLOW when any of:
//   (a) eact and etgt!=cur_dir, immediately, ignoring GREEN_MIN;
//   (b) !eact, other, count>=GREEN_MIN-1, and (!sensor[cur_dir] or count==GREEN_MAX-1).
//   With no other demand, or with eact and etgt==cur_dir, stay GREEN (rest in green).
// - YELLOW: light[cur_dir]=01. After YELLOW_T cycles (count==YELLOW_T-1), go to ALL_RED.
//   Yellow is never shortened, including by pre-emption.
// - At most one approach is non-red in any cycle. Yellow is always followed by >=ALLRED_T
//   cycles of all-red. These are invariants.
// - Lights are a combinational decode of the registered phase and cur_dir. No
//   combinational path exists from the inputs to the lights.
// - Reset mid-phase: outputs go to 00 immediately. The pending requests are lost.
// STRUCTURE
// - traffic_pkg (shared): dir_t {DIR_N,DIR_S,DIR_E,DIR_W} 2-bit;
//   phase_t {PH_ALL_RED,PH_GREEN,PH_YELLOW} 2-bit; light codes LT_RED=2'b00,
//   LT_YELLOW=2'b01, LT_GREEN=2'b10.
// - Sub-module rr_dir_picker: combinational. Inputs req[3:0] and last dir_t.
//   Outputs valid and next dir_t, using the rotating-priority scan above.
// - Top level: request latch, phase FSM with counter, and light decode.
// TESTING (defaults)
// 1. Release reset; sensor=0001 for 1 cycle at edge k. Required: pend[0]=1 after k,
//    n_lights=10 after k+1. With no other demand, N stays green for >=30 cycles.
// 2. N green, sensor[0] held 1, sensor[2] pulsed at green count 1. Required: N green
//    until count==11, then 2 cycles N=01, 1 cycle all 00, then e_lights=10.
// 3. N green, sensor[0]=0, sensor=1010 latched. Required: exit at count 3, then
//    2 cycles yellow, 1 cycle all-red, then S green (scan from N+1), later W green.
// 4. E green at count 1, emerg=0001. Required: next cycle e_lights=01 for 2 cycles,
//    1 cycle all-red, then n_lights=10. N holds green while emerg stays asserted.
// 5. emerg=0110 during ALL_RED. Required: S granted (lowest index), not round-robin
//    order.
// 6. Assert rst=0 mid-YELLOW on W. Required: all lights 00 and pend=0 with no clock
//    edge. After release, no green is issued until a sensor bit is set.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the intersection phase scheduler: approach directions,
// controller phases and the 2-bit light codes driven on each approach bus.
package traffic_pkg;

  typedef enum logic [1:0] {DIR_N, DIR_S, DIR_E, DIR_W} dir_t;

  typedef enum logic [1:0] {PH_ALL_RED, PH_GREEN, PH_YELLOW} phase_t;

  localparam logic [1:0] LT_RED    = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_GREEN  = 2'b10;

  function automatic logic [3:0] dir_onehot(input dir_t d);
    return 4'b0001 << d;
  endfunction

  // Lowest-indexed set bit wins; an empty vector maps to DIR_N.
  function automatic dir_t lowest_dir(input logic [3:0] v);
    dir_t d;
    d = DIR_N;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) d = dir_t'(2'(i));
    end
    return d;
  endfunction

endpackage

// File: rtl/rr_dir_picker.sv
// Rotating-priority direction picker: purely combinational, scans last+1,
// last+2, last+3 and finally last itself, returning the first requesting one.
module rr_dir_picker
  import traffic_pkg::*;
(
  input  logic [3:0] req,
  input  dir_t       last,
  output logic       valid,
  output dir_t       next
);

  logic [1:0] cand;

  always_comb begin
    valid = |req;
    next  = last;
    cand  = '0;
    // Walk from lowest to highest priority so the nearest requester overwrites.
    for (int k = 4; k >= 1; k--) begin
      cand = 2'(last) + 2'(k);
      if (req[cand]) next = dir_t'(cand);
    end
  end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-way phase scheduler with green extension, all-red clearance
// and emergency pre-emption; lights decode registered state only, so no input-to-light path.
module traffic_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 12,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sensor,
  input  logic [3:0] emerg,
  output logic [1:0] n_lights,
  output logic [1:0] s_lights,
  output logic [1:0] e_lights,
  output logic [1:0] w_lights,
  output logic [1:0] phase,
  output logic [1:0] cur_dir,
  output logic [3:0] pend
);

  localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_LAST    = CNT_W'(YELLOW_T - 1);

  phase_t           phase_q, phase_d;
  dir_t             dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_term;
  logic [3:0]       req_q, req_d;
  logic             eact, other, pick_vld;
  dir_t             etgt, pick_dir;
  logic [3:0][1:0]  lt;

  assign eact  = |emerg;
  assign etgt  = lowest_dir(emerg);
  assign other = |(req_q & ~dir_onehot(dir_q));

  rr_dir_picker u_picker (
    .req   (req_q),
    .last  (dir_q),
    .valid (pick_vld),
    .next  (pick_dir)
  );

  always_comb begin
    phase_d  = phase_q;
    dir_d    = dir_q;
    cnt_term = '0;
    case (phase_q)
      PH_ALL_RED: begin
        cnt_term = AR_LAST;
        if (cnt_q == AR_LAST && (eact || pick_vld)) begin
          phase_d = PH_GREEN;
          dir_d   = eact ? etgt : pick_dir;
        end
      end
      PH_GREEN: begin
        cnt_term = GMAX_LAST;
        // Pre-emption toward another approach bypasses the minimum green.
        if ((eact && etgt != dir_q) ||
            (!eact && other && cnt_q >= GMIN_LAST &&
             (!sensor[dir_q] || cnt_q == GMAX_LAST)))
          phase_d = PH_YELLOW;
      end
      PH_YELLOW: begin
        cnt_term = Y_LAST;
        if (cnt_q == Y_LAST) phase_d = PH_ALL_RED;
      end
      default: phase_d = PH_ALL_RED;
    endcase

    if (phase_d != phase_q)   cnt_d = '0;
    else if (cnt_q != cnt_term) cnt_d = cnt_q + 1'b1;
    else                      cnt_d = cnt_q;

    req_d = req_q | sensor | emerg;
    if (phase_q == PH_GREEN) req_d[dir_q] = req_q[dir_q];
    // The grant clear overrides any same-cycle request on the granted approach.
    if (phase_q == PH_ALL_RED && phase_d == PH_GREEN) req_d[dir_d] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_ALL_RED;
      cnt_q   <= '0;
      dir_q   <= DIR_W;
      req_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      req_q   <= req_d;
    end
  end

  always_comb begin
    lt = '0;
    if (phase_q == PH_GREEN)       lt[dir_q] = LT_GREEN;
    else if (phase_q == PH_YELLOW) lt[dir_q] = LT_YELLOW;
  end

  assign n_lights = lt[DIR_N];
  assign s_lights = lt[DIR_S];
  assign e_lights = lt[DIR_E];
  assign w_lights = lt[DIR_W];
  assign phase    = phase_q;
  assign cur_dir  = dir_q;
  assign pend     = req_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed scenarios with literal expectations
// plus a per-cycle comparison against a behavioural intersection model.
module tb_traffic_phase_scheduler;

  localparam int GREEN_MIN = 4;
  localparam int GREEN_MAX = 12;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sensor;
  logic [3:0] emerg;
  logic [1:0] n_lights, s_lights, e_lights, w_lights, phase, cur_dir;
  logic [3:0] pend;

  int tests = 0;
  int fails = 0;

  // Model state: 0 all-red, 1 green, 2 yellow; age counts cycles since phase entry.
  int       m_phase, m_age, m_dir;
  bit [3:0] m_req;

  traffic_phase_scheduler #(
    .GREEN_MIN (GREEN_MIN),
    .GREEN_MAX (GREEN_MAX),
    .YELLOW_T  (YELLOW_T),
    .ALLRED_T  (ALLRED_T),
    .CNT_W     (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sensor   (sensor),
    .emerg    (emerg),
    .n_lights (n_lights),
    .s_lights (s_lights),
    .e_lights (e_lights),
    .w_lights (w_lights),
    .phase    (phase),
    .cur_dir  (cur_dir),
    .pend     (pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    check(name, {14'b0, act}, {14'b0, exp});
  endtask

  task automatic chk_lights(input string name, input logic [7:0] exp);
    check(name, {8'b0, n_lights, s_lights, e_lights, w_lights}, {8'b0, exp});
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_age   = 0;
    m_dir   = 3;
    m_req   = 4'b0;
  endtask

  task automatic model_step();
    bit       eact, oth;
    int       etgt, nd;
    bit [3:0] nreq;
    eact = (emerg != 4'b0);
    etgt = 0;
    for (int i = 3; i >= 0; i--) if (emerg[i]) etgt = i;
    oth = 1'b0;
    for (int i = 0; i < 4; i++) if (i != m_dir && m_req[i]) oth = 1'b1;
    nreq = m_req | sensor | emerg;
    if (m_phase == 1) nreq[m_dir] = m_req[m_dir];
    case (m_phase)
      0: if (m_age >= ALLRED_T - 1 && (eact || m_req != 4'b0)) begin
           nd = -1;
           if (eact) nd = etgt;
           else for (int k = 1; k <= 4; k++)
             if (nd < 0 && m_req[(m_dir + k) % 4]) nd = (m_dir + k) % 4;
           nreq[nd] = 1'b0;
           m_dir = nd; m_phase = 1; m_age = 0;
         end else m_age++;
      1: if ((eact && etgt != m_dir) ||
             (!eact && oth && m_age >= GREEN_MIN - 1 &&
              (!sensor[m_dir] || m_age >= GREEN_MAX - 1))) begin
           m_phase = 2; m_age = 0;
         end else m_age++;
      default: if (m_age >= YELLOW_T - 1) begin
           m_phase = 0; m_age = 0;
         end else m_age++;
    endcase
    m_req = nreq;
  endtask

  task automatic model_loop();
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  endtask

  function automatic logic [15:0] model_vec();
    logic [1:0] l [4];
    for (int d = 0; d < 4; d++) begin
      l[d] = 2'b00;
      if (d == m_dir && m_phase == 1) l[d] = 2'b10;
      if (d == m_dir && m_phase == 2) l[d] = 2'b01;
    end
    return {2'(m_phase), 2'(m_dir), 4'(m_req), l[0], l[1], l[2], l[3]};
  endfunction

  task automatic compare_loop();
    int nr;
    forever begin
      @(negedge clk);
      check("cycle_model", {phase, cur_dir, pend, n_lights, s_lights, e_lights, w_lights},
            model_vec());
      nr = 0;
      if (n_lights != 2'b00) nr++;
      if (s_lights != 2'b00) nr++;
      if (e_lights != 2'b00) nr++;
      if (w_lights != 2'b00) nr++;
      check("one_nonred", {15'b0, nr <= 1}, 16'd1);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    sensor = 4'b0;
    emerg  = 4'b0;
    tick(2);
    rst = 1'b1;
  endtask

  // Leaves the bench at the first negedge of the granted green (count 0).
  task automatic grant_pulse(input logic [3:0] s);
    sensor = s;
    tick(1);
    sensor = 4'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1;
    sensor = 4'b0;
    emerg  = 4'b0;
    fork
      model_loop();
      compare_loop();
    join_none
    #1 rst = 1'b0;
    #2;
    chk_lights("reset_lights", 8'h00);
    check("reset_state", {8'b0, phase, cur_dir, pend}, {8'b0, 2'd0, 2'd3, 4'b0000});
    tick(2);
    rst = 1'b1;

    // Single N pulse: latched one cycle later, green one cycle after that, rests green.
    tick(1);
    sensor = 4'b0001;
    tick(1);
    sensor = 4'b0000;
    check("t1_pend", {12'b0, pend}, 16'h0001);
    chk2("t1_not_yet", n_lights, 2'b00);
    tick(1);
    chk2("t1_n_green", n_lights, 2'b10);
    check("t1_pend_clr", {12'b0, pend}, 16'h0000);
    tick(30);
    chk2("t1_rest_green", n_lights, 2'b10);

    // Extension by own sensor until GREEN_MAX, then yellow/all-red/E.
    do_reset();
    grant_pulse(4'b0001);
    sensor = 4'b0001;
    tick(1);
    sensor = 4'b0101;
    tick(1);
    sensor = 4'b0001;
    tick(9);
    chk2("t2_green_c11", n_lights, 2'b10);
    tick(1);
    chk2("t2_yel0", n_lights, 2'b01);
    tick(1);
    chk2("t2_yel1", n_lights, 2'b01);
    tick(1);
    chk_lights("t2_allred", 8'h00);
    tick(1);
    chk2("t2_e_green", e_lights, 2'b10);
    sensor = 4'b0000;

    // Gap-out at GREEN_MIN, rotating scan picks S then W.
    do_reset();
    grant_pulse(4'b0001);
    sensor = 4'b1010;
    tick(1);
    sensor = 4'b0000;
    tick(2);
    chk2("t3_green_c3", n_lights, 2'b10);
    tick(1);
    chk2("t3_yel0", n_lights, 2'b01);
    tick(1);
    chk2("t3_yel1", n_lights, 2'b01);
    tick(1);
    chk_lights("t3_allred", 8'h00);
    tick(1);
    chk2("t3_s_green", s_lights, 2'b10);
    chk2("t3_dir_s", cur_dir, 2'd1);
    tick(7);
    chk2("t3_w_green", w_lights, 2'b10);

    // Pre-emption of E green toward N.
    do_reset();
    grant_pulse(4'b0100);
    chk2("t4_e_green", e_lights, 2'b10);
    tick(1);
    emerg = 4'b0001;
    tick(1);
    chk2("t4_yel0", e_lights, 2'b01);
    tick(1);
    chk2("t4_yel1", e_lights, 2'b01);
    tick(1);
    chk_lights("t4_allred", 8'h00);
    tick(1);
    chk2("t4_n_green", n_lights, 2'b10);
    tick(10);
    chk2("t4_n_hold", n_lights, 2'b10);
    emerg = 4'b0000;
    tick(3);

    // Two simultaneous emergencies during all-red: lowest index wins.
    do_reset();
    emerg = 4'b0110;
    tick(1);
    chk2("t5_s_green", s_lights, 2'b10);
    chk2("t5_dir", cur_dir, 2'd1);
    check("t5_pend", {12'b0, pend}, 16'h0004);
    emerg = 4'b0000;
    tick(12);

    // Asynchronous reset in the middle of W yellow.
    do_reset();
    grant_pulse(4'b1000);
    chk2("t6_w_green", w_lights, 2'b10);
    sensor = 4'b0001;
    tick(1);
    sensor = 4'b0000;
    tick(3);
    chk2("t6_w_yel", w_lights, 2'b01);
    check("t6_pend_pre", {12'b0, pend}, 16'h0001);
    #2 rst = 1'b0;
    #1;
    chk_lights("t6_async_lights", 8'h00);
    check("t6_async_state", {10'b0, phase, pend}, 16'h0000);
    tick(1);
    rst = 1'b1;
    tick(10);
    chk_lights("t6_idle_lights", 8'h00);
    chk2("t6_idle_phase", phase, 2'd0);
    sensor = 4'b0010;
    tick(1);
    sensor = 4'b0000;
    tick(1);
    chk2("t6_s_green", s_lights, 2'b10);
    tick(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
